// File: rtl/sram_like_arbiter_if.sv
// Bus bundle for the N-to-1 SRAM-like arbiter: per-channel master signals and the single
// merged slave port.
interface sram_like_arbiter_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic [NUM_CH-1:0]          m_req;
    logic [NUM_CH-1:0]          m_wr;
    logic [2*NUM_CH-1:0]        m_size;
    logic [NUM_CH*DATA_W/8-1:0] m_wstrb;
    logic [NUM_CH*ADDR_W-1:0]   m_addr;
    logic [NUM_CH*DATA_W-1:0]   m_wdata;
    logic [NUM_CH-1:0]          m_addr_ok;
    logic [NUM_CH-1:0]          m_data_ok;
    logic [DATA_W-1:0]          m_rdata;

    logic                       s_req;
    logic                       s_wr;
    logic [1:0]                 s_size;
    logic [DATA_W/8-1:0]        s_wstrb;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic                       s_addr_ok;
    logic                       s_data_ok;
    logic [DATA_W-1:0]          s_rdata;

    modport master (
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport slave (
        input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
        output s_addr_ok, s_data_ok, s_rdata
    );

    modport arb (
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
        input  s_addr_ok, s_data_ok, s_rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Round-robin N-to-1 arbiter for the SRAM-like req/addr_ok/data_ok bus; an in-order ID
// FIFO steers each slave response back to the channel that issued it.
module sram_like_arbiter #(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    sram_like_arbiter_if.arb                   bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               resp_err
);
    localparam int unsigned IdW   = $clog2(NUM_CH);
    localparam int unsigned PtrW  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned StrbW = DATA_W / 8;

    typedef enum logic [0:0] {StArb, StLock} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  lock_id_q, lock_id_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [IdW-1:0]  fifo_d [MAX_OUTSTANDING];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            resp_err_q, resp_err_d;

    logic [IdW-1:0]  gnt;
    logic            gnt_vld;
    logic            sel_req;
    logic            issue_req;
    logic            full, empty, push, pop;
    int unsigned     idx;

    assign full  = (count_q == CntW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // While locked the grant is frozen so the slave sees stable fields until addr_ok.
    always_comb begin
        gnt     = rr_ptr_q;
        gnt_vld = 1'b0;
        idx     = 0;
        if (state_q == StLock) begin
            gnt     = lock_id_q;
            gnt_vld = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                idx = (32'(rr_ptr_q) + k) % NUM_CH;
                if (!gnt_vld && bus.m_req[idx]) begin
                    gnt     = IdW'(idx);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_req     = 1'b0;
        bus.s_wr    = 1'b0;
        bus.s_size  = '0;
        bus.s_wstrb = '0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt == IdW'(i)) begin
                sel_req     = bus.m_req[i];
                bus.s_wr    = bus.m_wr[i];
                bus.s_size  = bus.m_size[2*i +: 2];
                bus.s_wstrb = bus.m_wstrb[StrbW*i +: StrbW];
                bus.s_addr  = bus.m_addr[ADDR_W*i +: ADDR_W];
                bus.s_wdata = bus.m_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Reset gates the request combinationally so the slave sees nothing while rst is high.
    assign issue_req   = ~rst & gnt_vld & sel_req & ~full;
    assign bus.s_req   = issue_req;
    assign push        = issue_req & bus.s_addr_ok;
    assign pop         = ~rst & bus.s_data_ok & ~empty;
    assign bus.m_rdata = bus.s_rdata;

    always_comb begin
        bus.m_addr_ok = '0;
        bus.m_data_ok = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.m_addr_ok[i] = push && (gnt == IdW'(i));
            bus.m_data_ok[i] = pop && (fifo_q[rd_ptr_q] == IdW'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        rr_ptr_d   = rr_ptr_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        resp_err_d = resp_err_q;
        if (push) begin
            fifo_d[wr_ptr_q] = gnt;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            rr_ptr_d         = (gnt == IdW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
            state_d          = StArb;
        end else if (issue_req) begin
            state_d   = StLock;
            lock_id_d = gnt;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (bus.s_data_ok && empty) begin
            resp_err_d = 1'b1;
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StArb;
            lock_id_q  <= '0;
            rr_ptr_q   <= '0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            rr_ptr_q   <= rr_ptr_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign outstanding = count_q;
    assign resp_err    = resp_err_q;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: hand-derived vector table, directed corner sequences and a
// random phase checked against a queue-based reference model.
module tb_sram_like_arbiter;
    localparam int unsigned NumCh  = 2;
    localparam int unsigned AddrW  = 32;
    localparam int unsigned DataW  = 32;
    localparam int unsigned MaxOut = 4;
    localparam int unsigned CntW   = $clog2(MaxOut) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_like_arbiter_if #(.NUM_CH(NumCh), .ADDR_W(AddrW), .DATA_W(DataW)) bus ();
    logic [CntW-1:0] outstanding;
    logic            resp_err;

    sram_like_arbiter #(
        .NUM_CH(NumCh), .ADDR_W(AddrW), .DATA_W(DataW), .MAX_OUTSTANDING(MaxOut)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding), .resp_err(resp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ch_addr  [NumCh];
    logic [31:0] ch_wdata [NumCh];
    logic        ch_wr    [NumCh];
    logic [1:0]  ch_size  [NumCh];
    logic [3:0]  ch_wstrb [NumCh];

    // Reference model: issued channel IDs in order, round-robin start, lock and error flag.
    int   q[$];
    int   rr;
    bit   locked;
    int   lock_ch;
    bit   err;
    logic [NumCh-1:0] last_eaok;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [NumCh-1:0] req, input bit aok, input bit dok,
                          input logic [31:0] rdata);
        for (int c = 0; c < NumCh; c++) begin
            bus.m_wr[c]              = ch_wr[c];
            bus.m_size[2*c +: 2]     = ch_size[c];
            bus.m_wstrb[4*c +: 4]    = ch_wstrb[c];
            bus.m_addr[32*c +: 32]   = ch_addr[c];
            bus.m_wdata[32*c +: 32]  = ch_wdata[c];
        end
        bus.m_req     = req;
        bus.s_addr_ok = aok;
        bus.s_data_ok = dok;
        bus.s_rdata   = rdata;
    endtask

    task automatic model_reset();
        q.delete();
        rr      = 0;
        locked  = 0;
        lock_ch = 0;
        err     = 0;
    endtask

    function automatic int model_gnt();
        if (locked) return lock_ch;
        for (int k = 0; k < NumCh; k++) begin
            int c = (rr + k) % NumCh;
            if (bus.m_req[c]) return c;
        end
        return -1;
    endfunction

    // Called at the falling edge: check outputs, then advance the model at the rising edge.
    task automatic model_cycle();
        int g;
        bit sreq;
        bit pop;
        logic [NumCh-1:0] eaok, edok;
        g    = model_gnt();
        sreq = !rst && (g >= 0) && bus.m_req[g] && (q.size() < MaxOut);
        eaok = '0;
        if (sreq && bus.s_addr_ok) eaok[g] = 1'b1;
        pop  = bus.s_data_ok && (q.size() > 0);
        edok = '0;
        if (pop) edok[q[0]] = 1'b1;
        check("s_req", bus.s_req, sreq);
        if (sreq) begin
            check("s_addr", bus.s_addr, ch_addr[g]);
            check("s_wdata", bus.s_wdata, ch_wdata[g]);
            check("s_wr", bus.s_wr, ch_wr[g]);
            check("s_size", bus.s_size, ch_size[g]);
            check("s_wstrb", bus.s_wstrb, ch_wstrb[g]);
        end
        check("m_addr_ok", bus.m_addr_ok, eaok);
        check("m_data_ok", bus.m_data_ok, edok);
        if (pop) check("m_rdata", bus.m_rdata, bus.s_rdata);
        check("outstanding", outstanding, q.size());
        check("resp_err", resp_err, err);
        last_eaok = eaok;
        @(posedge clk);
        if (bus.s_data_ok) begin
            if (q.size() > 0) void'(q.pop_front());
            else err = 1;
        end
        if (sreq) begin
            if (bus.s_addr_ok) begin
                q.push_back(g);
                rr     = (g + 1) % NumCh;
                locked = 0;
            end else begin
                locked  = 1;
                lock_ch = g;
            end
        end
        #1;
    endtask

    task automatic step(input logic [NumCh-1:0] req, input bit aok, input bit dok,
                        input logic [31:0] rdata);
        set_in(req, aok, dok, rdata);
        @(negedge clk);
        model_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in('0, 0, 0, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  req;
        bit          aok;
        bit          dok;
        logic [31:0] rdata;
        bit          e_sreq;
        int          e_ch;
        logic [1:0]  e_aok;
        logic [1:0]  e_dok;
        int          e_out;
    } vec_t;

    function automatic vec_t mkvec(logic [1:0] req, bit aok, bit dok, logic [31:0] rdata,
                                   bit e_sreq, int e_ch, logic [1:0] e_aok,
                                   logic [1:0] e_dok, int e_out);
        vec_t v;
        v.req = req; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.e_sreq = e_sreq; v.e_ch = e_ch; v.e_aok = e_aok; v.e_dok = e_dok; v.e_out = e_out;
        return v;
    endfunction

    initial begin
        vec_t vt[$];
        bit   pending [NumCh];

        ch_addr[0] = 32'h0000_1000; ch_wdata[0] = 32'haaaa_0000; ch_wr[0] = 1'b0;
        ch_size[0] = 2'd2;          ch_wstrb[0] = 4'hf;
        ch_addr[1] = 32'h0000_2000; ch_wdata[1] = 32'hbbbb_1111; ch_wr[1] = 1'b1;
        ch_size[1] = 2'd1;          ch_wstrb[1] = 4'h3;
        model_reset();

        rst = 1'b1;
        set_in('0, 0, 0, '0);
        #12;
        check("reset s_req", bus.s_req, 1'b0);
        check("reset m_addr_ok", bus.m_addr_ok, 2'b00);
        check("reset m_data_ok", bus.m_data_ok, 2'b00);
        check("reset outstanding", outstanding, 0);
        check("reset resp_err", resp_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        //                req    aok dok rdata          sreq ch  aok    dok    out
        vt.push_back(mkvec(2'b00, 0, 0, 32'h0,         0, -1, 2'b00, 2'b00, 0));
        vt.push_back(mkvec(2'b01, 1, 0, 32'h0,         1,  0, 2'b01, 2'b00, 0));
        vt.push_back(mkvec(2'b00, 0, 1, 32'h1234_5678, 0, -1, 2'b00, 2'b01, 1));
        vt.push_back(mkvec(2'b11, 1, 0, 32'h0,         1,  1, 2'b10, 2'b00, 0));
        vt.push_back(mkvec(2'b11, 1, 0, 32'h0,         1,  0, 2'b01, 2'b00, 1));
        vt.push_back(mkvec(2'b11, 1, 1, 32'hcafe_0001, 1,  1, 2'b10, 2'b10, 2));
        vt.push_back(mkvec(2'b11, 0, 0, 32'h0,         1,  0, 2'b00, 2'b00, 2));
        vt.push_back(mkvec(2'b11, 0, 1, 32'hcafe_0002, 1,  0, 2'b00, 2'b01, 2));
        vt.push_back(mkvec(2'b11, 1, 0, 32'h0,         1,  0, 2'b01, 2'b00, 1));
        vt.push_back(mkvec(2'b11, 1, 0, 32'h0,         1,  1, 2'b10, 2'b00, 2));
        vt.push_back(mkvec(2'b11, 1, 0, 32'h0,         1,  0, 2'b01, 2'b00, 3));
        vt.push_back(mkvec(2'b11, 1, 0, 32'h0,         0, -1, 2'b00, 2'b00, 4));
        vt.push_back(mkvec(2'b11, 1, 1, 32'hcafe_0003, 0, -1, 2'b00, 2'b10, 4));
        vt.push_back(mkvec(2'b11, 1, 0, 32'h0,         1,  1, 2'b10, 2'b00, 3));
        vt.push_back(mkvec(2'b00, 0, 1, 32'hcafe_0004, 0, -1, 2'b00, 2'b01, 4));

        for (int i = 0; i < vt.size(); i++) begin
            set_in(vt[i].req, vt[i].aok, vt[i].dok, vt[i].rdata);
            @(negedge clk);
            check($sformatf("vec%0d s_req", i), bus.s_req, vt[i].e_sreq);
            if (vt[i].e_ch >= 0)
                check($sformatf("vec%0d s_addr", i), bus.s_addr, ch_addr[vt[i].e_ch]);
            check($sformatf("vec%0d m_addr_ok", i), bus.m_addr_ok, vt[i].e_aok);
            check($sformatf("vec%0d m_data_ok", i), bus.m_data_ok, vt[i].e_dok);
            if (vt[i].e_dok != 2'b00)
                check($sformatf("vec%0d m_rdata", i), bus.m_rdata, vt[i].rdata);
            check($sformatf("vec%0d outstanding", i), outstanding, vt[i].e_out);
            model_cycle();
        end

        // Lock: ch1 stalls for three cycles while ch0 waits.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in((i == 0) ? 2'b10 : 2'b11, (i == 3), 0, '0);
            @(negedge clk);
            check("lock s_addr", bus.s_addr, ch_addr[1]);
            check("lock m_addr_ok", bus.m_addr_ok, (i == 3) ? 2'b10 : 2'b00);
            model_cycle();
        end
        set_in(2'b11, 1, 0, '0);
        @(negedge clk);
        check("after lock s_addr", bus.s_addr, ch_addr[0]);
        check("after lock m_addr_ok", bus.m_addr_ok, 2'b01);
        model_cycle();

        // Full: four reads block issue until a response drains one.
        do_reset();
        for (int i = 0; i < 4; i++) step(2'b01, 1, 0, '0);
        set_in(2'b01, 1, 1, 32'h5555_aaaa);
        @(negedge clk);
        check("full s_req", bus.s_req, 1'b0);
        check("full outstanding", outstanding, 4);
        model_cycle();
        set_in(2'b01, 1, 0, '0);
        @(negedge clk);
        check("drained s_req", bus.s_req, 1'b1);
        check("drained outstanding", outstanding, 3);
        model_cycle();

        // Response with empty FIFO sets sticky error.
        do_reset();
        set_in(2'b00, 0, 1, 32'hdead_beef);
        @(negedge clk);
        check("empty m_data_ok", bus.m_data_ok, 2'b00);
        model_cycle();
        for (int i = 0; i < 2; i++) begin
            step(2'b00, 0, 0, '0);
            check("sticky resp_err", resp_err, 1'b1);
        end

        // Asynchronous reset with three outstanding, no clock edge.
        for (int i = 0; i < 3; i++) step(2'b11, 1, 0, '0);
        set_in(2'b11, 0, 0, '0);
        #2;
        check("pre-rst outstanding", outstanding, 3);
        rst = 1'b1;
        #1;
        check("async rst outstanding", outstanding, 0);
        check("async rst s_req", bus.s_req, 1'b0);
        check("async rst resp_err", resp_err, 1'b0);
        check("async rst m_addr_ok", bus.m_addr_ok, 2'b00);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic: masters hold req until addr_ok, slave answers in order.
        do_reset();
        for (int c = 0; c < NumCh; c++) pending[c] = 0;
        for (int n = 0; n < 800; n++) begin
            logic [NumCh-1:0] req;
            for (int c = 0; c < NumCh; c++) begin
                if (!pending[c] && ($urandom % 3 == 0)) begin
                    pending[c]  = 1;
                    ch_addr[c]  = $urandom;
                    ch_wdata[c] = $urandom;
                    ch_wr[c]    = 1'($urandom % 2);
                    ch_size[c]  = 2'($urandom % 3);
                    ch_wstrb[c] = 4'($urandom);
                end
                req[c] = pending[c];
            end
            step(req, 1'($urandom % 2), (q.size() > 0) && ($urandom % 2 == 1), $urandom);
            for (int c = 0; c < NumCh; c++) if (last_eaok[c]) pending[c] = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
